mat_loader: RTL and testbench

MAT_LOADER -- requirements
Module: mat_loader

---
 rtl/mat_loader.sv | 142 ++++++++++++++
 tb/tb_mat_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_loader.sv
// Streams two NxN signed matrices (A row-major, B transposed on write), then raises
// a fixed-length compute enable for the downstream multiplier and holds done until acknowledged.
module mat_loader #(
    parameter int N_ROWS      = 2,
    parameter int N_COLUMNS   = 2,
    parameter int DW          = 8,
    parameter int CALC_CYCLES = N_ROWS + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 enable,
    output int                   mat1 [0:N_ROWS-1][0:N_COLUMNS-1],
    output int                   mat2 [0:N_ROWS-1][0:N_COLUMNS-1],
    output logic                 done,
    input  logic                 done_ack
);

    localparam int N     = N_ROWS;
    localparam int NN    = N * N;
    localparam int CNT_W = $clog2(NN + 1);
    localparam int CYC_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(NN - 1);
    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(CALC_CYCLES - 1);

    generate
        if (N_ROWS != N_COLUMNS) begin : g_shape_check
            $error("mat_loader: N_ROWS must equal N_COLUMNS");
        end
        if (CALC_CYCLES < 1) begin : g_calc_check
            $error("mat_loader: CALC_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        COMPUTE,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] elemCnt_q, elemCnt_d;
    logic [CYC_W-1:0] cycCnt_q, cycCnt_d;
    logic             inReady_q, inReady_d;

    int               mat1_q [0:N-1][0:N-1];
    int               mat2_q [0:N-1][0:N-1];

    logic             accept;
    logic             lastElem;
    logic             wrA;
    logic             wrB;
    int               elemExt;

    // in_ready comes only from a register, so acceptance never loops back through in_valid
    assign accept   = in_valid && inReady_q;
    assign lastElem = accept && (elemCnt_q == LAST_ELEM);
    assign wrA      = accept && (state_q == LOAD_A);
    assign wrB      = accept && (state_q == LOAD_B);
    assign elemExt  = int'(in_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LOAD_A;
            elemCnt_q <= '0;
            cycCnt_q  <= '0;
            inReady_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            elemCnt_q <= elemCnt_d;
            cycCnt_q  <= cycCnt_d;
            inReady_q <= inReady_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        elemCnt_d = elemCnt_q;
        cycCnt_d  = cycCnt_q;
        case (state_q)
            LOAD_A, LOAD_B: begin
                if (lastElem) begin
                    elemCnt_d = '0;
                    state_d   = (state_q == LOAD_A) ? LOAD_B : COMPUTE;
                end else if (accept) begin
                    elemCnt_d = elemCnt_q + 1'b1;
                end
            end
            COMPUTE: begin
                if (cycCnt_q == LAST_CYC) begin
                    cycCnt_d = '0;
                    state_d  = HOLD;
                end else begin
                    cycCnt_d = cycCnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (done_ack) begin
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
        inReady_d = (state_d == LOAD_A) || (state_d == LOAD_B);
    end

    // Element k lands at A[k/N][k%N] and at B-transposed [k%N][k/N]
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mat1_q[r][c] <= 0;
                    mat2_q[r][c] <= 0;
                end
            end
        end else begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (wrA && (elemCnt_q == CNT_W'(r * N + c))) begin
                        mat1_q[r][c] <= elemExt;
                    end
                    if (wrB && (elemCnt_q == CNT_W'(r * N + c))) begin
                        mat2_q[c][r] <= elemExt;
                    end
                end
            end
        end
    end

    assign mat1     = mat1_q;
    assign mat2     = mat2_q;
    assign in_ready = inReady_q;
    assign enable   = (state_q == COMPUTE);
    assign done     = (state_q == HOLD);

endmodule

// File: tb/tb_mat_loader.sv
// Directed bench for mat_loader with N=2, DW=8, CALC_CYCLES=3: loading, sign extension,
// gapped streams, ignored input during compute/hold, done handshake and asynchronous reset.
module tb_mat_loader;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic signed [7:0] in_data;
    logic             in_ready;
    logic             enable;
    int               mat1 [0:1][0:1];
    int               mat2 [0:1][0:1];
    logic             done;
    logic             done_ack;

    int checkCount;
    int errorCount;

    mat_loader #(
        .N_ROWS(2),
        .N_COLUMNS(2),
        .DW(8),
        .CALC_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .enable(enable),
        .mat1(mat1),
        .mat2(mat2),
        .done(done),
        .done_ack(done_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Streams eight elements (A then B) back to back; returns in the first COMPUTE cycle
    task automatic loadAll(input int vals [8]);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(vals[i]);
            stepClk();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        done_ack = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkCount++;
        if (in_ready !== 1'b0 || enable !== 1'b0 || done !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_outputs: got ready=%b en=%b done=%b expected 0 0 0", in_ready, enable, done);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                checkCount++;
                if (mat1[r][c] !== 0 || mat2[r][c] !== 0) begin
                    errorCount++;
                    $display("[TB] FAIL reset_mats[%0d][%0d]: got %0d/%0d expected 0/0", r, c, mat1[r][c], mat2[r][c]);
                end
            end
        end
        stepClk();
        stepClk();
        reset = 1'b1;
        checkCount++;
        if (in_ready !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_release_ready: got %b expected 0", in_ready);
        end
        stepClk();
        checkCount++;
        if (in_ready !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int v [8];
        int expA [2][2];
        int expB [2][2];
        v    = '{1, 2, 3, 4, 5, 6, 7, 8};
        expA = '{'{1, 2}, '{3, 4}};
        expB = '{'{5, 7}, '{6, 8}};
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (in_ready !== 1'b1 || enable !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL b2b_load_%0d: got ready=%b en=%b expected 1 0", i, in_ready, enable);
            end
            in_valid = 1'b1;
            in_data  = 8'(v[i]);
            stepClk();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkCount++;
            if (enable !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL b2b_compute_%0d: got en=%b done=%b ready=%b expected 1 0 0", k, enable, done, in_ready);
            end
            stepClk();
        end
        checkCount++;
        if (enable !== 1'b0 || done !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL b2b_hold: got en=%b done=%b expected 0 1", enable, done);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                checkCount++;
                if (mat1[r][c] !== expA[r][c] || mat2[r][c] !== expB[r][c]) begin
                    errorCount++;
                    $display("[TB] FAIL b2b_mats[%0d][%0d]: got %0d/%0d expected %0d/%0d",
                             r, c, mat1[r][c], mat2[r][c], expA[r][c], expB[r][c]);
                end
            end
        end
        done_ack = 1'b1;
        stepClk();
        done_ack = 1'b0;
        checkCount++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL b2b_ack: got done=%b ready=%b expected 0 1", done, in_ready);
        end
    endtask

    task automatic test_sign_ext();
        int v [8];
        int expA [2][2];
        int expB [2][2];
        v    = '{255, 128, 127, 0, 128, 255, 1, 127};
        expA = '{'{-1, -128}, '{127, 0}};
        expB = '{'{-128, 1}, '{-1, 127}};
        loadAll(v);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                checkCount++;
                if (mat1[r][c] !== expA[r][c] || mat2[r][c] !== expB[r][c]) begin
                    errorCount++;
                    $display("[TB] FAIL sign_mats[%0d][%0d]: got %0d/%0d expected %0d/%0d",
                             r, c, mat1[r][c], mat2[r][c], expA[r][c], expB[r][c]);
                end
            end
        end
        stepClk();
        stepClk();
        stepClk();
        done_ack = 1'b1;
        stepClk();
        done_ack = 1'b0;
    endtask

    task automatic test_gaps();
        int expA [2][2];
        int expB [2][2];
        expA = '{'{1, 2}, '{3, 4}};
        expB = '{'{5, 7}, '{6, 8}};
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            stepClk();
            if (i < 7) begin
                in_valid = 1'b0;
                in_data  = 8'h55;
                stepClk();
                checkCount++;
                if (in_ready !== 1'b1 || enable !== 1'b0) begin
                    errorCount++;
                    $display("[TB] FAIL gap_%0d_state: got ready=%b en=%b expected 1 0", i, in_ready, enable);
                end
            end
            if (i == 0) begin
                checkCount++;
                if (mat1[0][0] !== 1 || mat1[0][1] !== -128) begin
                    errorCount++;
                    $display("[TB] FAIL gap_hold: got %0d,%0d expected 1,-128", mat1[0][0], mat1[0][1]);
                end
            end
        end
        in_valid = 1'b0;
        checkCount++;
        if (enable !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL gap_enable: got %b expected 1", enable);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                checkCount++;
                if (mat1[r][c] !== expA[r][c] || mat2[r][c] !== expB[r][c]) begin
                    errorCount++;
                    $display("[TB] FAIL gap_mats[%0d][%0d]: got %0d/%0d expected %0d/%0d",
                             r, c, mat1[r][c], mat2[r][c], expA[r][c], expB[r][c]);
                end
            end
        end
        stepClk();
        stepClk();
        stepClk();
        done_ack = 1'b1;
        stepClk();
        done_ack = 1'b0;
    endtask

    task automatic test_ignore_busy();
        int v [8];
        int expA [2][2];
        int expB [2][2];
        v    = '{10, 11, 12, 13, 14, 15, 16, 17};
        expA = '{'{10, 11}, '{12, 13}};
        expB = '{'{14, 16}, '{15, 17}};
        loadAll(v);
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + k);
            checkCount++;
            if (in_ready !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL busy_ready_%0d: got %b expected 0", k, in_ready);
            end
            stepClk();
        end
        in_valid = 1'b0;
        checkCount++;
        if (done !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL busy_done: got %b expected 1", done);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                checkCount++;
                if (mat1[r][c] !== expA[r][c] || mat2[r][c] !== expB[r][c]) begin
                    errorCount++;
                    $display("[TB] FAIL busy_mats[%0d][%0d]: got %0d/%0d expected %0d/%0d",
                             r, c, mat1[r][c], mat2[r][c], expA[r][c], expB[r][c]);
                end
            end
        end
        done_ack = 1'b1;
        stepClk();
        done_ack = 1'b0;
    endtask

    task automatic test_done_ack_wait();
        int v [8];
        v = '{1, 2, 3, 4, 5, 6, 7, 8};
        done_ack = 1'b1;
        loadAll(v);
        stepClk();
        stepClk();
        done_ack = 1'b0;
        checkCount++;
        if (enable !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL ack_ignored_compute: got en=%b expected 1", enable);
        end
        stepClk();
        for (int k = 0; k < 10; k++) begin
            checkCount++;
            if (done !== 1'b1 || in_ready !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL hold_wait_%0d: got done=%b ready=%b expected 1 0", k, done, in_ready);
            end
            stepClk();
        end
        done_ack = 1'b1;
        stepClk();
        done_ack = 1'b0;
        checkCount++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL hold_release: got done=%b ready=%b expected 0 1", done, in_ready);
        end
    endtask

    task automatic test_reset_midload();
        int expA [2][2];
        int expB [2][2];
        expA = '{'{21, 22}, '{23, 24}};
        expB = '{'{25, 27}, '{26, 28}};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(9 + i);
            stepClk();
        end
        reset = 1'b0;
        #1;
        checkCount++;
        if (in_ready !== 1'b0 || enable !== 1'b0 || done !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL midload_reset_out: got ready=%b en=%b done=%b expected 0 0 0", in_ready, enable, done);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                checkCount++;
                if (mat1[r][c] !== 0 || mat2[r][c] !== 0) begin
                    errorCount++;
                    $display("[TB] FAIL midload_reset_mats[%0d][%0d]: got %0d/%0d expected 0/0", r, c, mat1[r][c], mat2[r][c]);
                end
            end
        end
        stepClk();
        in_valid = 1'b0;
        stepClk();
        reset = 1'b1;
        stepClk();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(21 + i);
            stepClk();
            if (i == 0) begin
                checkCount++;
                if (mat1[0][0] !== 21) begin
                    errorCount++;
                    $display("[TB] FAIL fresh_first: got %0d expected 21", mat1[0][0]);
                end
            end
        end
        in_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                checkCount++;
                if (mat1[r][c] !== expA[r][c] || mat2[r][c] !== expB[r][c]) begin
                    errorCount++;
                    $display("[TB] FAIL fresh_mats[%0d][%0d]: got %0d/%0d expected %0d/%0d",
                             r, c, mat1[r][c], mat2[r][c], expA[r][c], expB[r][c]);
                end
            end
        end
        stepClk();
        reset = 1'b0;
        #1;
        checkCount++;
        if (enable !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL midcompute_reset: got en=%b done=%b ready=%b expected 0 0 0", enable, done, in_ready);
        end
        stepClk();
        reset = 1'b1;
        stepClk();
        checkCount++;
        if (in_ready !== 1'b1 || enable !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL midcompute_recover: got ready=%b en=%b expected 1 0", in_ready, enable);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        test_reset();
        test_back_to_back();
        test_sign_ext();
        test_gaps();
        test_ignore_busy();
        test_done_ack_wait();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
